// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: one single-port RAM shared by the VGA scan-out path
// (prefetch FIFO, two pixels per word) and a req/ack drawing engine.
module vga_fb_arbiter #(
    parameter int          FIFO_DEPTH      = 8,
    parameter int          URGENT_LEVEL    = 3,
    parameter int          FRAME_WORDS     = 153600,
    parameter int          ADDR_W          = 18,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              blank,
    output logic [23:0]       RGB,
    output logic              underflow,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [47:0]       wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [47:0]       ram_wdata,
    input  logic [47:0]       ram_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W:0]    PEND_URGENT = (LVL_W+1)'(URGENT_LEVEL);
    localparam logic [LVL_W:0]    PEND_FULL   = (LVL_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   FRAME_END   = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [47:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [LVL_W-1:0]   r_level;
    // r_rd_q1: read address is on the port; r_rd_q2: its data is on ram_rdata
    logic               r_rd_q1, r_rd_q2;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic               r_sel, r_underflow, r_wr_ack, r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [47:0]        r_ram_wdata;

    logic [LVL_W:0]     w_pending;
    logic               w_wr_ok, w_wr_go, w_rd_go;
    logic               w_active, w_empty, w_push, w_pop;
    logic [47:0]        w_head;
    logic [23:0]        w_rgb;

    // A request already acked this cycle is the previous one still held high.
    assign w_wr_ok   = wr_req & ~r_wr_ack;
    assign w_pending = {1'b0, r_level} + {{LVL_W{1'b0}}, r_rd_q1} + {{LVL_W{1'b0}}, r_rd_q2};
    assign w_empty   = (r_level == {LVL_W{1'b0}});
    assign w_active  = blank & (r_state != ST_IDLE);
    assign w_head    = r_fifo[r_rptr];
    assign w_pop     = w_active & ~w_empty & r_sel;
    assign w_push    = r_rd_q2 & ~frame_start;

    // Next state and the single port grant for this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_go     = 1'b0;
        w_wr_go     = 1'b0;
        if (frame_start) begin
            w_state_nxt = ST_FLUSH;
            w_wr_go     = w_wr_ok;
        end else begin
            case (r_state)
                ST_IDLE: w_wr_go = w_wr_ok;
                ST_FLUSH: begin
                    w_wr_go     = w_wr_ok;
                    w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_pending < PEND_URGENT) begin
                        w_rd_go = 1'b1;
                    end else if (w_wr_ok) begin
                        w_wr_go = 1'b1;
                    end else if (w_pending < PEND_FULL) begin
                        w_rd_go = 1'b1;
                    end else begin
                        w_rd_go = 1'b0;
                    end
                    if (w_rd_go && (r_fetch_addr == LAST_ADDR)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DONE: w_wr_go = w_wr_ok;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pixel mux straight off the FIFO head, no added latency.
    always_comb begin
        w_rgb = 24'h000000;
        if (!w_active) begin
            w_rgb = 24'h000000;
        end else if (w_empty) begin
            w_rgb = UNDERFLOW_COLOR;
        end else if (r_sel) begin
            w_rgb = w_head[47:24];
        end else begin
            w_rgb = w_head[23:0];
        end
    end

    // State, read pipeline flags and fetch address.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_IDLE;
            r_rd_q1      <= 1'b0;
            r_rd_q2      <= 1'b0;
            r_fetch_addr <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_rd_q1 <= w_rd_go;
            r_rd_q2 <= r_rd_q1 & ~frame_start;
            if (frame_start) begin
                r_fetch_addr <= {ADDR_W{1'b0}};
            end else if (w_rd_go) begin
                r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
            end
        end
    end

    // Registered RAM port and write acknowledge; out-of-frame writes are acked but dropped.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_ram_wdata <= 48'h0;
            r_ram_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
        end else if (w_wr_go) begin
            r_ram_addr  <= wr_addr;
            r_ram_wdata <= wr_data;
            r_ram_we    <= ({1'b0, wr_addr} < FRAME_END);
            r_wr_ack    <= 1'b1;
        end else if (w_rd_go) begin
            r_ram_addr  <= r_fetch_addr;
            r_ram_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
        end else begin
            r_ram_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
        end
    end

    // FIFO bookkeeping, pixel select and sticky underflow; frame_start clears them
    // so the FLUSH cycle already sees an empty FIFO.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wptr      <= {PTR_W{1'b0}};
            r_rptr      <= {PTR_W{1'b0}};
            r_level     <= {LVL_W{1'b0}};
            r_sel       <= 1'b0;
            r_underflow <= 1'b0;
        end else if (frame_start) begin
            r_wptr      <= {PTR_W{1'b0}};
            r_rptr      <= {PTR_W{1'b0}};
            r_level     <= {LVL_W{1'b0}};
            r_sel       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_active) r_sel <= ~r_sel;
            if (w_active && w_empty) r_underflow <= 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge Clock) begin
        if (w_push) r_fifo[r_wptr] <= ram_rdata;
    end

    assign RGB       = w_rgb;
    assign underflow = r_underflow;
    assign wr_ack    = r_wr_ack;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
endmodule
